serial_rx: RTL and testbench

- UART-style serial receiver and the counterpart of the team's serial transmitter.
- Frame format: 1 start bit (0), 8 data bits LSB first, odd parity bit, 1 stop bit (1). Line idles at 1.
- Oversamples the asynchronous line at 16x baud from the system clock, checks parity and stop, and presents each byte to the host through a valid/ack handshake.
- Sits between the board RX pin and the host logic (terminal/keyboard path).

---
 rtl/serial_rx.sv | 152 +++++++++++++++
 tb/tb_serial_rx.sv | 140 ++++++++++++++
 2 files changed

// File: rtl/serial_rx.sv
// serial_rx: 16x-oversampling UART receiver (8 data bits, odd parity, 1 stop).
// Delivers each byte with parity/frame status through a valid/ack handshake.
module serial_rx #(
  parameter int CLK_FREQ = 100000000,
  parameter int BAUD     = 115200
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rx_in,
  input  logic       rx_ack,
  output logic [7:0] data,
  output logic       rx_valid,
  output logic       parity_err,
  output logic       frame_err,
  output logic       overrun_err,
  output logic       rx_busy
);

  localparam int DIV = CLK_FREQ / (BAUD * 16);
  localparam int DW  = (DIV > 1) ? $clog2(DIV) : 1;

  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;

  state_t        state, state_nx;
  logic          rx_m, rx_s;
  logic [DW-1:0] div_cnt;
  logic          tick;
  logic [3:0]    smp;
  logic [2:0]    idx;
  logic [7:0]    shift;
  logic          par_bit;

  logic start_det, smp_clr, smp_inc, shift_en, par_en, done;

  // Two-flop synchronizer for the asynchronous line; idles high
  always_ff @(posedge clk) begin
    if (rst) begin
      rx_m <= 1'b1;
      rx_s <= 1'b1;
    end else begin
      rx_m <= rx_in;
      rx_s <= rx_m;
    end
  end

  assign tick = (div_cnt == DW'(DIV - 1));

  // Free-running oversample divider: one tick every DIV clocks
  always_ff @(posedge clk) begin
    if (rst || tick) div_cnt <= '0;
    else             div_cnt <= div_cnt + DW'(1);
  end

  // State register
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  // Next-state and per-tick control strobes; smp wraps 15->0 in the 16-tick bit states
  always_comb begin
    state_nx  = state;
    start_det = 1'b0;
    smp_clr   = 1'b0;
    smp_inc   = 1'b0;
    shift_en  = 1'b0;
    par_en    = 1'b0;
    done      = 1'b0;
    if (tick) begin
      case (state)
        IDLE: begin
          if (!rx_s) begin
            state_nx  = START;
            start_det = 1'b1;
            smp_clr   = 1'b1;
          end
        end
        START: begin
          if (smp == 4'd7) begin
            smp_clr  = 1'b1;
            state_nx = rx_s ? IDLE : DATA;
          end else begin
            smp_inc = 1'b1;
          end
        end
        DATA: begin
          smp_inc = 1'b1;
          if (smp == 4'd15) begin
            shift_en = 1'b1;
            if (idx == 3'd7) state_nx = PARITY;
          end
        end
        PARITY: begin
          smp_inc = 1'b1;
          if (smp == 4'd15) begin
            par_en   = 1'b1;
            state_nx = STOP;
          end
        end
        STOP: begin
          smp_inc = 1'b1;
          if (smp == 4'd15) begin
            done     = 1'b1;
            state_nx = IDLE;
          end
        end
        default: state_nx = IDLE;
      endcase
    end
  end

  // Sample counter, bit index, shift register and parity capture
  always_ff @(posedge clk) begin
    if (rst) begin
      smp     <= '0;
      idx     <= '0;
      shift   <= '0;
      par_bit <= 1'b0;
    end else begin
      if (smp_clr)      smp <= '0;
      else if (smp_inc) smp <= smp + 4'd1;
      if (start_det)    idx <= '0;
      else if (shift_en) idx <= idx + 3'd1;
      if (shift_en)     shift[idx] <= rx_s;
      if (par_en)       par_bit <= rx_s;
    end
  end

  // Output register and handshake; completion with a same-clock ack counts as a clean handoff
  always_ff @(posedge clk) begin
    if (rst) begin
      data        <= '0;
      rx_valid    <= 1'b0;
      parity_err  <= 1'b0;
      frame_err   <= 1'b0;
      overrun_err <= 1'b0;
    end else if (done) begin
      data       <= shift;
      parity_err <= ~(^shift ^ par_bit);
      frame_err  <= ~rx_s;
      rx_valid   <= 1'b1;
      if (rx_valid && !rx_ack) overrun_err <= 1'b1;
      else if (rx_valid)       overrun_err <= 1'b0;
    end else if (rx_valid && rx_ack) begin
      rx_valid    <= 1'b0;
      overrun_err <= 1'b0;
    end
  end

  assign rx_busy = (state != IDLE);

endmodule

// File: tb/tb_serial_rx.sv
// tb_serial_rx: directed bench for serial_rx at 16 clocks per bit.
module tb_serial_rx;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       rx_in = 1'b1;
  logic       rx_ack = 1'b0;
  logic [7:0] data;
  logic       rx_valid, parity_err, frame_err, overrun_err, rx_busy;

  int ntotal = 0;
  int npass  = 0;

  serial_rx #(.CLK_FREQ(1600), .BAUD(100)) dut (
    .clk(clk), .rst(rst), .rx_in(rx_in), .rx_ack(rx_ack),
    .data(data), .rx_valid(rx_valid), .parity_err(parity_err),
    .frame_err(frame_err), .overrun_err(overrun_err), .rx_busy(rx_busy)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    ntotal++;
    assert (obs === exp) npass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic send_bit(input logic b);
    rx_in = b;
    repeat (16) step();
  endtask

  task automatic send_frame(input logic [7:0] d, input logic p, input logic stp);
    send_bit(1'b0);
    for (int i = 0; i < 8; i++) send_bit(d[i]);
    send_bit(p);
    send_bit(stp);
    rx_in = 1'b1;
  endtask

  task automatic ack();
    rx_ack = 1'b1;
    step();
    rx_ack = 1'b0;
  endtask

  task automatic check_outs(input string tag, input logic [7:0] d, input logic v,
                            input logic pe, input logic fe, input logic oe);
    check({tag, ".data"},    data,        d);
    check({tag, ".valid"},   {7'd0, rx_valid},    {7'd0, v});
    check({tag, ".par_err"}, {7'd0, parity_err},  {7'd0, pe});
    check({tag, ".frm_err"}, {7'd0, frame_err},   {7'd0, fe});
    check({tag, ".ovr_err"}, {7'd0, overrun_err}, {7'd0, oe});
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic saw_busy;

    // Reset state
    repeat (3) step();
    check_outs("reset", 8'h00, 1'b0, 1'b0, 1'b0, 1'b0);
    check("reset.busy", {7'd0, rx_busy}, 8'd0);
    rst = 1'b0;
    repeat (5) step();

    // Good frame, then ack
    send_frame(8'hA5, 1'b1, 1'b1);
    repeat (4) step();
    check_outs("good", 8'hA5, 1'b1, 1'b0, 1'b0, 1'b0);
    ack();
    check("good_ack.valid", {7'd0, rx_valid}, 8'd0);
    check("good_ack.data", data, 8'hA5);
    ack();
    check("stray_ack.valid", {7'd0, rx_valid}, 8'd0);

    // Parity error
    send_frame(8'h3C, 1'b0, 1'b1);
    repeat (4) step();
    check_outs("parity", 8'h3C, 1'b1, 1'b1, 1'b0, 1'b0);
    ack();

    // Framing error; line returns high, no phantom frame afterwards
    send_frame(8'h00, 1'b1, 1'b0);
    repeat (4) step();
    check_outs("frame", 8'h00, 1'b1, 1'b0, 1'b1, 1'b0);
    ack();
    repeat (200) step();
    check("frame_after.valid", {7'd0, rx_valid}, 8'd0);
    check("frame_after.busy", {7'd0, rx_busy}, 8'd0);

    // Glitch rejection: 4-clk low pulse
    saw_busy = 1'b0;
    rx_in = 1'b0;
    for (int i = 0; i < 4; i++) begin step(); saw_busy |= rx_busy; end
    rx_in = 1'b1;
    for (int i = 0; i < 30; i++) begin step(); saw_busy |= rx_busy; end
    check("glitch.saw_busy", {7'd0, saw_busy}, 8'd1);
    check("glitch.busy", {7'd0, rx_busy}, 8'd0);
    check("glitch.valid", {7'd0, rx_valid}, 8'd0);
    check("glitch.data", data, 8'h00);

    // Overrun: two frames back to back without ack
    send_frame(8'h11, 1'b1, 1'b1);
    send_frame(8'h22, 1'b1, 1'b1);
    repeat (4) step();
    check_outs("overrun", 8'h22, 1'b1, 1'b0, 1'b0, 1'b1);
    ack();
    check("overrun_ack.valid", {7'd0, rx_valid}, 8'd0);
    check("overrun_ack.ovr", {7'd0, overrun_err}, 8'd0);

    // Reset mid-frame after data bit 3 of 0xFF
    send_bit(1'b0);
    for (int i = 0; i < 4; i++) send_bit(1'b1);
    rx_in = 1'b1;
    rst = 1'b1;
    step();
    rst = 1'b0;
    check_outs("midrst", 8'h00, 1'b0, 1'b0, 1'b0, 1'b0);
    check("midrst.busy", {7'd0, rx_busy}, 8'd0);
    repeat (5) step();
    send_frame(8'h5A, 1'b1, 1'b1);
    repeat (4) step();
    check_outs("after_rst", 8'h5A, 1'b1, 1'b0, 1'b0, 1'b0);

    $display("%0d/%0d checks passed", npass, ntotal);
    $finish;
  end

endmodule
